// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with count, almost flags and overflow/underflow pulses; 1-cycle registered read, or 0-cycle read when FIFO_FWFT_EN is defined.
// Backpressure: a write while full or a read while empty is dropped with no state change and flagged by a one-cycle overflow/underflow pulse.
module fifo_sync_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_THR = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_THR = AE_LVL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              wr_acc;
    logic              rd_acc;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign count        = wptr - rptr;
    assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty        = (wptr == rptr);
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            overflow  <= wen && full;
            underflow <= ren && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is visible directly; value is meaningless while empty.
    assign data_out = mem[rptr[ADDR_W-1:0]];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule
